pipe_hazard_ctrl: RTL and testbench

Hazard and stall controller for the ARM pipeline's decode/execute/memory stages. Each cycle it produces the stall, flush and forward-select controls that sequence the D→E pipeline register and its neighbours. It covers load-use interlocks, taken-branch redirects and multi-cycle data-memory waits. A timeout watchdog and a saturating stall-cycle counter provide error detection and performance visibility.

---
 rtl/pipe_hazard_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard and stall controller for the decode/execute/memory stages of the
// ARM pipeline. It derives stall, flush and forward-select controls every
// cycle. These cover load-use interlocks, taken-branch redirects and
// multi-cycle data-memory waits. A watchdog flags data-memory waits that run
// too long, and a saturating counter records how many cycles Decode stalled.
//
// Ports
//   clk                      clock, all state updates on the rising edge
//   reset                    synchronous active-low reset
//   RA1D, RA2D               source registers of the Decode instruction
//   RA1E, RA2E               source registers of the Execute instruction
//   WA3E, WA3M, WA3W         destination registers in Execute/Memory/Writeback
//   RegWriteE/M/W            destination write enables per stage
//   MemtoRegE                Execute instruction is a load
//   PCSrcE                   taken branch / PC write resolved in Execute
//   MemValidM, MemReadyM     data-memory access handshake in Memory
//   StallF/D/E/M             hold the corresponding pipeline register
//   FlushD, FlushE           clear the corresponding pipeline register
//   ForwardAE, ForwardBE     operand source: 00 regfile, 01 WB, 10 MEM
//   TimeoutErr               sticky watchdog error
//   StallCount               saturating count of cycles with StallD=1
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
   parameter int MAX_WAIT = 15,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       RA1D,
   input  logic [3:0]       RA2D,
   input  logic [3:0]       RA1E,
   input  logic [3:0]       RA2E,
   input  logic [3:0]       WA3E,
   input  logic [3:0]       WA3M,
   input  logic [3:0]       WA3W,
   input  logic             RegWriteE,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             MemtoRegE,
   input  logic             PCSrcE,
   input  logic             MemValidM,
   input  logic             MemReadyM,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             TimeoutErr,
   output logic [CNT_W-1:0] StallCount
);

   localparam logic [1:0] ST_RUN     = 2'd0;
   localparam logic [1:0] ST_MEMWAIT = 2'd1;
   localparam logic [1:0] ST_ERROR   = 2'd2;

   // Last MEMWAIT wait_cnt value before the watchdog fires. The RUN entry
   // cycle already counts as one not-ready cycle, so ERROR follows exactly
   // MAX_WAIT+1 consecutive not-ready cycles.
   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [1:0]       state_q, state_d;
   logic [7:0]       wait_q, wait_d;
   logic             tmo_q, tmo_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             memstall;
   logic             ldstall;

   // Forward source for one Execute operand; the Memory result wins over
   // Writeback, and R15 is never forwarded.
   function automatic logic [1:0] fwd_sel(input logic [3:0] ra,
                                          input logic [3:0] wa_m,
                                          input logic [3:0] wa_w,
                                          input logic       we_m,
                                          input logic       we_w);
      logic [1:0] sel;
      if (ra == 4'hF) begin
         sel = 2'b00;
      end else if (we_m && (wa_m == ra)) begin
         sel = 2'b10;
      end else if (we_w && (wa_w == ra)) begin
         sel = 2'b01;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   // Hazard detection terms.
   always_comb begin
      memstall = ((state_q == ST_RUN) && MemValidM && !MemReadyM) ||
                 ((state_q == ST_MEMWAIT) && !MemReadyM) ||
                 (state_q == ST_ERROR);
      ldstall  = MemtoRegE && RegWriteE && ((WA3E == RA1D) || (WA3E == RA2D));
   end

   // Mealy stall/flush/forward outputs; a memory wait overrides everything else.
   always_comb begin
      ForwardAE = fwd_sel(RA1E, WA3M, WA3W, RegWriteM, RegWriteW);
      ForwardBE = fwd_sel(RA2E, WA3M, WA3W, RegWriteM, RegWriteW);
      if (memstall) begin
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
         FlushD = 1'b0;
         FlushE = 1'b0;
      end else begin
         StallF = ldstall;
         StallD = ldstall;
         StallE = 1'b0;
         StallM = 1'b0;
         FlushD = PCSrcE;
         FlushE = ldstall || PCSrcE;
      end
   end

   // Next-state logic for the FSM, watchdog counter and sticky error.
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      tmo_d   = tmo_q;
      case (state_q)
         ST_RUN: begin
            wait_d = 8'd0;
            if (MemValidM && !MemReadyM) begin
               state_d = ST_MEMWAIT;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_MEMWAIT: begin
            if (MemReadyM) begin
               state_d = ST_RUN;
               wait_d  = 8'd0;
            end else if (wait_q == WAIT_LAST) begin
               state_d = ST_ERROR;
               wait_d  = wait_q + 8'd1;
               tmo_d   = 1'b1;
            end else begin
               wait_d  = wait_q + 8'd1;
            end
         end
         ST_ERROR: begin
            tmo_d = 1'b1;
         end
         default: begin
            state_d = ST_RUN;
            wait_d  = 8'd0;
         end
      endcase
   end

   // Saturating stall-cycle counter increment.
   always_comb begin
      if (StallD && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_ONE;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_RUN;
         wait_q  <= 8'd0;
         tmo_q   <= 1'b0;
         cnt_q   <= {CNT_W{1'b0}};
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         tmo_q   <= tmo_d;
         cnt_q   <= cnt_d;
      end
   end

   assign TimeoutErr = tmo_q;
   assign StallCount = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed-vector bench for pipe_hazard_ctrl (MAX_WAIT=15, CNT_W=4). The
// driver sets inputs just after a rising edge and queues the hand-computed
// output word for that cycle. A monitor pops the queue on the falling edge
// and compares it against the DUT outputs.
// Output word: {StallF,StallD,StallE,StallM,FlushD,FlushE,ForwardAE,
//               ForwardBE,TimeoutErr,StallCount[3:0]}
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

   logic       clk;
   logic       reset;
   logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
   logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, PCSrcE;
   logic       MemValidM, MemReadyM;
   logic       StallF, StallD, StallE, StallM, FlushD, FlushE, TimeoutErr;
   logic [1:0] ForwardAE, ForwardBE;
   logic [3:0] StallCount;

   logic [14:0] exp_q[$];
   string       name_q[$];
   int          total = 0;
   int          bad   = 0;
   logic [14:0] mon_exp;
   logic [14:0] mon_act;
   string       mon_name;

   pipe_hazard_ctrl #(.MAX_WAIT(15), .CNT_W(4)) dut (
      .clk(clk), .reset(reset),
      .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
      .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
      .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .MemtoRegE(MemtoRegE), .PCSrcE(PCSrcE),
      .MemValidM(MemValidM), .MemReadyM(MemReadyM),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .TimeoutErr(TimeoutErr), .StallCount(StallCount)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [14:0] e(input logic sf, input logic sd,
                                     input logic se, input logic sm,
                                     input logic fd, input logic fe,
                                     input logic [1:0] fa, input logic [1:0] fb,
                                     input logic to, input logic [3:0] c);
      return {sf, sd, se, sm, fd, fe, fa, fb, to, c};
   endfunction

   task automatic clear_in();
      RA1D = 4'd0; RA2D = 4'd0; RA1E = 4'd0; RA2E = 4'd0;
      WA3E = 4'd0; WA3M = 4'd0; WA3W = 4'd0;
      RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
      MemtoRegE = 1'b0; PCSrcE = 1'b0; MemValidM = 1'b0; MemReadyM = 1'b0;
   endtask

   // Queue the expectation for the current cycle, then move to the next one.
   task automatic vec(input string nm, input logic [14:0] ex);
      exp_q.push_back(ex);
      name_q.push_back(nm);
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare DUT outputs against queued expectations mid-cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_exp  = exp_q.pop_front();
         mon_name = name_q.pop_front();
         mon_act  = {StallF, StallD, StallE, StallM, FlushD, FlushE,
                     ForwardAE, ForwardBE, TimeoutErr, StallCount};
         total = total + 1;
         if (mon_act !== mon_exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %b expected %b", mon_name, mon_act, mon_exp);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      clear_in();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      vec("reset_state", e(0,0,0,0,0,0,2'b00,2'b00,0,4'd0));

      // Forwarding priority and R15 exclusion.
      RA1E = 4'd3; WA3M = 4'd3; RegWriteM = 1'b1; WA3W = 4'd3; RegWriteW = 1'b1;
      vec("fwd_mem", e(0,0,0,0,0,0,2'b10,2'b00,0,4'd0));
      RegWriteM = 1'b0;
      vec("fwd_wb", e(0,0,0,0,0,0,2'b01,2'b00,0,4'd0));
      RegWriteM = 1'b1; RA1E = 4'hF; WA3M = 4'hF; WA3W = 4'hF;
      vec("fwd_r15", e(0,0,0,0,0,0,2'b00,2'b00,0,4'd0));
      RA1E = 4'd2; WA3M = 4'd2; RA2E = 4'd7; WA3W = 4'd7;
      vec("fwd_ab", e(0,0,0,0,0,0,2'b10,2'b01,0,4'd0));
      clear_in();

      // Load-use interlock lasts one cycle.
      MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd5; RA2D = 4'd5;
      vec("ldstall", e(1,1,0,0,0,1,2'b00,2'b00,0,4'd0));
      clear_in();
      WA3M = 4'd5; RegWriteM = 1'b1;
      vec("ld_after", e(0,0,0,0,0,0,2'b00,2'b00,0,4'd1));
      clear_in();

      // Branch alone, then branch together with a load-use stall.
      PCSrcE = 1'b1;
      vec("branch", e(0,0,0,0,1,1,2'b00,2'b00,0,4'd1));
      MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd4; RA1D = 4'd4;
      vec("branch_ld", e(1,1,0,0,1,1,2'b00,2'b00,0,4'd1));
      clear_in();
      vec("branch_ld_after", e(0,0,0,0,0,0,2'b00,2'b00,0,4'd2));

      // Branch held during a 3-cycle memory wait, then the ready cycle.
      MemValidM = 1'b1; MemReadyM = 1'b0; PCSrcE = 1'b1;
      for (int i = 0; i < 3; i++) begin
         vec($sformatf("memwait_br%0d", i), e(1,1,1,1,0,0,2'b00,2'b00,0,4'(2 + i)));
      end
      MemReadyM = 1'b1;
      vec("memwait_ready", e(0,0,0,0,1,1,2'b00,2'b00,0,4'd5));
      clear_in();
      vec("memwait_done", e(0,0,0,0,0,0,2'b00,2'b00,0,4'd5));

      // Ready in the same cycle as valid: no stall and no state change.
      MemValidM = 1'b1; MemReadyM = 1'b1;
      vec("mem_fast", e(0,0,0,0,0,0,2'b00,2'b00,0,4'd5));
      MemValidM = 1'b0; MemReadyM = 1'b0;
      vec("mem_fast_after", e(0,0,0,0,0,0,2'b00,2'b00,0,4'd5));

      // Quiet reset, then run into the watchdog.
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      MemValidM = 1'b1; MemReadyM = 1'b0;
      for (int i = 0; i < 16; i++) begin
         vec($sformatf("tmo_wait%0d", i), e(1,1,1,1,0,0,2'b00,2'b00,0,4'(i)));
      end
      MemReadyM = 1'b1;
      vec("err_ready", e(1,1,1,1,0,0,2'b00,2'b00,1,4'd15));
      MemValidM = 1'b0; MemReadyM = 1'b0; PCSrcE = 1'b1;
      vec("err_branch", e(1,1,1,1,0,0,2'b00,2'b00,1,4'd15));
      clear_in();
      reset = 1'b0;
      vec("err_in_reset", e(1,1,1,1,0,0,2'b00,2'b00,1,4'd15));
      reset = 1'b1;
      vec("err_cleared", e(0,0,0,0,0,0,2'b00,2'b00,0,4'd0));

      // Stall counter saturation with a held load-use stall.
      MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd5; RA2D = 4'd5;
      for (int i = 0; i < 20; i++) begin
         vec($sformatf("sat%0d", i),
             e(1,1,0,0,0,1,2'b00,2'b00,0,(i > 15) ? 4'd15 : 4'(i)));
      end
      clear_in();
      vec("sat_hold", e(0,0,0,0,0,0,2'b00,2'b00,0,4'd15));

      // Reset applied mid-MEMWAIT returns to RUN.
      MemValidM = 1'b1; MemReadyM = 1'b0;
      vec("mw0", e(1,1,1,1,0,0,2'b00,2'b00,0,4'd15));
      vec("mw1", e(1,1,1,1,0,0,2'b00,2'b00,0,4'd15));
      clear_in();
      reset = 1'b0;
      vec("mw_in_reset", e(1,1,1,1,0,0,2'b00,2'b00,0,4'd15));
      reset = 1'b1;
      vec("mw_after0", e(0,0,0,0,0,0,2'b00,2'b00,0,4'd0));
      vec("mw_after1", e(0,0,0,0,0,0,2'b00,2'b00,0,4'd0));

      @(negedge clk);
      total = total + 1;
      if (exp_q.size() != 0) begin
         bad = bad + 1;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
